spec_scan_ctrl: RTL and testbench
=================================

Name: spec_scan_ctrl

Overview:
- Sequences one spectrum-capture cycle around the 203-bin modulus RAM that holds the window around 2 MHz.
- On a start request it clears the RAM writer, waits for its write-complete flag, then reads every bin back once.
- During the read-back it finds the peak value, the peak bin index, and the number of bins above a threshold.
- It reports the results with a done pulse, which drives the recognition logic downstream.

Parameters:
- NBINS, 203: number of RAM bins to scan, addresses 0..NBINS-1.
- RD_LAT, 1: RAM read latency in clocks, from rd_en/rd_addr to valid rd_data. Legal range 1..3.
- THRESH, 16'd1000: a bin is counted when its value is strictly greater than THRESH.
- ARM_CYCLES, 4: number of clocks wr_clr_n is held low.
- TIMEOUT, 24'd10_000_000: maximum clocks to wait for wr_done before aborting.

Ports:
- clk  input  1  FFT clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle start request; already synchronised and debounced.
- wr_done  input  1  level from the RAM writer; high once all bins are written.
- rd_data  input  16  RAM read data.
- wr_clr_n  output  1  active-low clear to the RAM writer (ANDed into its reset).
- rd_en  output  1  RAM read enable.
- rd_addr  output  8  RAM read address.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when results are updated.
- timeout_err  output  1  sticky flag, set on a wr_done timeout, cleared by the next accepted start.
- peak_val  output  16  maximum bin value from the last completed scan.
- peak_idx  output  8  lowest address holding peak_val.
- above_cnt  output  8  count of bins greater than THRESH.

Behaviour:
- Reset values: state=IDLE, wr_clr_n=1, rd_en=0, rd_addr=0, busy=0, done=0, timeout_err=0, peak_val=0, peak_idx=0, above_cnt=0.
- All outputs are registered.
- State IDLE:
  - start=1 -> ARM; clear timeout_err.
  - start in any other state is ignored.
- State ARM:
  - wr_clr_n=0 for exactly ARM_CYCLES clocks.
  - Then go to WAIT, with wr_clr_n=1 and the wait counter at 0.
- State WAIT:
  - While wr_done=0, the counter increments each clock.
  - Counter reaches TIMEOUT-1 with wr_done still 0 -> set timeout_err, go to IDLE. No done pulse; results are unchanged.
  - wr_done=1 is sampled in the first WAIT cycle at the earliest. This guards against a stale level from the previous run, because the writer is cleared in ARM.
  - wr_done=1 -> SCAN. Clear the running max, index and count, and set rd_addr=0.
- State SCAN:
  - rd_en=1 for exactly NBINS consecutive clocks, with rd_addr stepping 0..NBINS-1.
  - A tag pipeline RD_LAT deep, carrying a valid bit and an 8-bit index, aligns each index with its rd_data.
  - Per valid sample: if rd_data > running_max (strict), update the max and the index. Ties therefore keep the lower index.
  - Per valid sample: if rd_data > THRESH, increment the count, saturating at 255.
  - After the last address is issued, rd_en=0 and rd_addr returns to 0. Go to DRAIN.
- State DRAIN:
  - Wait until the tag pipeline is empty (RD_LAT clocks).
  - Then copy the running values to peak_val, peak_idx and above_cnt, pulse done for 1 clock, and go to IDLE.
  - The result outputs change only on the done cycle, so they are stable between scans.
- Latency from the wr_done sample to done is NBINS + RD_LAT + 1 clocks (205 at defaults).
- Arithmetic: comparisons are unsigned 16-bit; the NBINS address counter is 8 bits wide.
- wr_done dropping during SCAN has no effect; the scan completes.
- Asynchronous reset mid-operation: every state and output returns immediately to its reset value.
- An all-zero RAM gives peak_val=0, peak_idx=0, above_cnt=0.

Test Plan:
- Reset, then start. Writer model asserts wr_done 50 clocks after wr_clr_n rises. RAM holds value = address, except bin 100 = 5000, THRESH=1000. Required: wr_clr_n low exactly 4 clocks; done 205 clocks after the wr_done sample; peak_val=5000, peak_idx=100, above_cnt=1.
- Bins 30 and 150 both 7000, all others 0. Required: peak_idx=30, above_cnt=2.
- All bins 2000. Required: above_cnt=203, peak_idx=0. Repeat with a RAM model of RD_LAT=3 and check identical results.
- TIMEOUT=100 and wr_done never asserted. Required: timeout_err=1 at clock 100 of WAIT, busy drops, no done pulse, previous results retained. The next start clears timeout_err.
- start pulses during ARM, WAIT and SCAN. Required: no restart, single done per run. wr_done held high from the previous run is not sampled before the first WAIT cycle.
- rst_n asserted at address 80 of SCAN. Required: rd_en=0, busy=0, all results 0 immediately. A fresh start then completes normally.

Source files
------------

// File: rtl/spec_scan_ctrl.sv
// Spectrum-capture sequencer: clears the modulus RAM writer, waits for it to
// finish, then reads every bin once to find the peak and the above-threshold count.
module spec_scan_ctrl #(
  parameter int unsigned NBINS      = 203,
  parameter int unsigned RD_LAT     = 1,
  parameter logic [15:0] THRESH     = 16'd1000,
  parameter int unsigned ARM_CYCLES = 4,
  parameter logic [23:0] TIMEOUT    = 24'd10_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        wr_done,
  input  logic [15:0] rd_data,
  output logic        wr_clr_n,
  output logic        rd_en,
  output logic [7:0]  rd_addr,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [15:0] peak_val,
  output logic [7:0]  peak_idx,
  output logic [7:0]  above_cnt
);

  typedef enum logic [2:0] {IDLE, ARM, WAIT, SCAN, DRAIN} state_t;

  localparam logic [7:0]  LAST_ADDR = 8'(NBINS - 1);
  localparam logic [7:0]  ARM_LAST  = 8'(ARM_CYCLES - 1);
  localparam logic [23:0] TO_LAST   = TIMEOUT - 24'd1;

  state_t      state, state_nx;
  logic [7:0]  arm_cnt;
  logic [23:0] wait_cnt;

  logic [RD_LAT-1:0] tag_v;
  logic [7:0]        tag_idx [RD_LAT];

  logic [15:0] run_max;
  logic [7:0]  run_idx;
  logic [7:0]  run_cnt;

  logic       wr_clr_n_d, rd_en_d, busy_d, done_d;
  logic [7:0] rd_addr_d;
  logic       accept, scan_go, to_hit;
  logic       smp_v;
  logic [7:0] smp_idx;

  assign smp_v   = tag_v[RD_LAT-1];
  assign smp_idx = tag_idx[RD_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ARM;
      ARM:     if (arm_cnt == ARM_LAST) state_nx = WAIT;
      WAIT: begin
        if (wr_done)                   state_nx = SCAN;
        else if (wait_cnt == TO_LAST)  state_nx = IDLE;
      end
      SCAN:    if (rd_addr == LAST_ADDR) state_nx = DRAIN;
      DRAIN:   if (tag_v == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they line up with it.
  always_comb begin
    wr_clr_n_d = (state_nx != ARM);
    rd_en_d    = (state_nx == SCAN);
    rd_addr_d  = (state == SCAN && state_nx == SCAN) ? rd_addr + 8'd1 : '0;
    busy_d     = (state_nx != IDLE);
    done_d     = (state == DRAIN) && (state_nx == IDLE);
    accept     = (state == IDLE) && (state_nx == ARM);
    scan_go    = (state == WAIT) && (state_nx == SCAN);
    to_hit     = (state == WAIT) && (state_nx == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_clr_n    <= 1'b1;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      peak_val    <= '0;
      peak_idx    <= '0;
      above_cnt   <= '0;
      arm_cnt     <= '0;
      wait_cnt    <= '0;
      tag_v       <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) tag_idx[i] <= '0;
      run_max     <= '0;
      run_idx     <= '0;
      run_cnt     <= '0;
    end else begin
      wr_clr_n <= wr_clr_n_d;
      rd_en    <= rd_en_d;
      rd_addr  <= rd_addr_d;
      busy     <= busy_d;
      done     <= done_d;

      if (accept)      timeout_err <= 1'b0;
      else if (to_hit) timeout_err <= 1'b1;

      arm_cnt  <= (state == ARM && state_nx == ARM) ? arm_cnt + 8'd1 : '0;
      wait_cnt <= (state == WAIT && state_nx == WAIT) ? wait_cnt + 24'd1 : '0;

      // Tag pipeline tracks each issued address until its data returns.
      tag_v[0]   <= rd_en;
      tag_idx[0] <= rd_addr;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end

      if (scan_go) begin
        run_max <= '0;
        run_idx <= '0;
        run_cnt <= '0;
      end else if (smp_v) begin
        if (rd_data > run_max) begin
          run_max <= rd_data;
          run_idx <= smp_idx;
        end
        if (rd_data > THRESH && run_cnt != 8'hFF) run_cnt <= run_cnt + 8'd1;
      end

      if (done_d) begin
        peak_val  <= run_max;
        peak_idx  <= run_idx;
        above_cnt <= run_cnt;
      end
    end
  end

endmodule

// File: tb/tb_spec_scan_ctrl.sv
// Scoreboard bench for spec_scan_ctrl: two DUTs (read latency 1 and 3) share
// stimulus; expected scan results come from a direct model of the RAM contents.
module tb_spec_scan_ctrl;

  localparam int unsigned NBINS  = 203;
  localparam logic [15:0] THRESH = 16'd1000;
  localparam int unsigned ARMC   = 4;
  localparam logic [23:0] TMO    = 24'd100;

  typedef struct packed {
    logic [15:0] v;
    logic [7:0]  i;
    logic [7:0]  c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  int   wmode = 0;
  int   cyc = 0;

  logic [15:0] ram [256];
  exp_t        exp_mem [64];
  int          exp_wr = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic [1:0]       wr_done, wr_clr_n, rd_en, busy, done, timeout_err;
  logic [1:0][7:0]  rd_addr, peak_idx, above_cnt;
  logic [1:0][15:0] rd_data, peak_val;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int unsigned LAT = (g == 0) ? 1 : 3;

    spec_scan_ctrl #(.NBINS(NBINS), .RD_LAT(LAT), .THRESH(THRESH),
                     .ARM_CYCLES(ARMC), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .wr_done(wr_done[g]),
      .rd_data(rd_data[g]), .wr_clr_n(wr_clr_n[g]), .rd_en(rd_en[g]),
      .rd_addr(rd_addr[g]), .busy(busy[g]), .done(done[g]),
      .timeout_err(timeout_err[g]), .peak_val(peak_val[g]),
      .peak_idx(peak_idx[g]), .above_cnt(above_cnt[g]));

    // Writer: done 50 clocks after clear releases; mode 1 never, mode 2 stuck high.
    logic [7:0] wcnt;
    logic       wd;
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wcnt <= 8'd0; wd <= 1'b0;
      end else if (!wr_clr_n[g]) begin
        wcnt <= 8'd0; wd <= 1'b0;
      end else if (wcnt != 8'd50) begin
        wcnt <= wcnt + 8'd1;
      end else if (wmode == 0) begin
        wd <= 1'b1;
      end
    end
    assign wr_done[g] = (wmode == 2) ? 1'b1 : wd;

    // RAM with LAT clocks of read latency; garbage when not enabled.
    logic [15:0] pipe [LAT];
    always @(posedge clk) begin
      pipe[0] <= rd_en[g] ? ram[rd_addr[g]] : 16'hFFFF;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign rd_data[g] = pipe[LAT-1];

    initial begin : mon
      int   rd_ptr, lowc, t_rd, en_cnt, addr_err;
      logic prev_en;
      exp_t e;
      rd_ptr = 0; lowc = 0; t_rd = 0; en_cnt = 0; addr_err = 0; prev_en = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          rd_ptr = exp_wr; lowc = 0; prev_en = 1'b0;
        end else begin
          if (!wr_clr_n[g]) lowc++;
          else if (lowc != 0) begin
            check($sformatf("lane%0d clr_low_len", g), lowc, ARMC);
            lowc = 0;
          end
          if (rd_en[g] && !prev_en) begin
            t_rd = cyc; en_cnt = 0; addr_err = 0;
          end
          if (rd_en[g]) begin
            if (rd_addr[g] != 8'(en_cnt)) addr_err++;
            en_cnt++;
          end else if (prev_en && rd_addr[g] != 8'd0) addr_err++;
          prev_en = rd_en[g];
          if (done[g]) begin
            if (rd_ptr == exp_wr) begin
              n_checks++; n_fail++;
              $display("FAIL lane%0d unexpected_done: done=1, required no pending scan", g);
            end else begin
              e = exp_mem[rd_ptr % 64];
              rd_ptr++;
              check($sformatf("lane%0d peak_val", g), peak_val[g], e.v);
              check($sformatf("lane%0d peak_idx", g), peak_idx[g], e.i);
              check($sformatf("lane%0d above_cnt", g), above_cnt[g], e.c);
              check($sformatf("lane%0d latency", g), cyc - t_rd, NBINS + LAT + 1);
              check($sformatf("lane%0d rd_en_len", g), en_cnt, NBINS);
              check($sformatf("lane%0d addr_seq_err", g), addr_err, 0);
            end
          end
        end
      end
    end
  end

  function automatic exp_t ref_model();
    exp_t r;
    int best, cnt;
    bit found;
    best = 0; cnt = 0; found = 0;
    r = '0;
    for (int a = 0; a < int'(NBINS); a++) if (int'(ram[a]) > best) best = int'(ram[a]);
    for (int a = 0; a < int'(NBINS); a++) begin
      if (!found && int'(ram[a]) == best) begin r.i = 8'(a); found = 1; end
      if (ram[a] > THRESH) cnt++;
    end
    r.v = 16'(best);
    r.c = 8'((cnt > 255) ? 255 : cnt);
    return r;
  endfunction

  task automatic push_exp();
    exp_mem[exp_wr % 64] = ref_model();
    exp_wr++;
  endtask

  task automatic fill_const(input logic [15:0] v);
    for (int a = 0; a < 256; a++) ram[a] = v;
  endtask

  task automatic fill_random();
    for (int a = 0; a < 256; a++) begin
      case ($urandom_range(0, 3))
        0: ram[a] = 16'($urandom_range(0, 1000));
        1: ram[a] = 16'($urandom_range(1000, 1001));
        2: ram[a] = 16'($urandom);
        default: ram[a] = ram[0];
      endcase
    end
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done();
    int  k;
    bit  s0, s1;
    k = 0; s0 = 0; s1 = 0;
    while (!(s0 && s1) && k < 1000) begin
      @(negedge clk);
      k++;
      if (done[0]) s0 = 1;
      if (done[1]) s1 = 1;
    end
    check("done_seen", {31'd0, s0 && s1}, 1);
  endtask

  task automatic run_scan();
    push_exp();
    do_start();
    wait_done();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    exp_t prev;
    int   k;
    fill_const(16'd0);
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst lane%0d wr_clr_n", g), wr_clr_n[g], 1);
      check($sformatf("rst lane%0d rd_en", g), rd_en[g], 0);
      check($sformatf("rst lane%0d rd_addr", g), rd_addr[g], 0);
      check($sformatf("rst lane%0d busy", g), busy[g], 0);
      check($sformatf("rst lane%0d done", g), done[g], 0);
      check($sformatf("rst lane%0d timeout_err", g), timeout_err[g], 0);
      check($sformatf("rst lane%0d peak_val", g), peak_val[g], 0);
      check($sformatf("rst lane%0d peak_idx", g), peak_idx[g], 0);
      check($sformatf("rst lane%0d above_cnt", g), above_cnt[g], 0);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // value = address with a single large bin
    for (int a = 0; a < 256; a++) ram[a] = 16'(a);
    ram[100] = 16'd5000;
    run_scan();

    // tie between two bins keeps the lower index
    fill_const(16'd0);
    ram[30] = 16'd7000; ram[150] = 16'd7000;
    run_scan();

    fill_const(16'd2000);
    run_scan();

    fill_const(16'd0);
    run_scan();

    repeat (4) begin
      fill_random();
      run_scan();
    end

    // wr_done timeout: results retained, flag set at the 100th WAIT clock
    prev = exp_mem[(exp_wr - 1) % 64];
    wmode = 1;
    do_start();
    repeat (103) @(negedge clk);
    check("to pre timeout_err", timeout_err[0], 0);
    check("to pre busy", busy[0], 1);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("to lane%0d timeout_err", g), timeout_err[g], 1);
      check($sformatf("to lane%0d busy", g), busy[g], 0);
      check($sformatf("to lane%0d peak_val", g), peak_val[g], prev.v);
      check($sformatf("to lane%0d peak_idx", g), peak_idx[g], prev.i);
      check($sformatf("to lane%0d above_cnt", g), above_cnt[g], prev.c);
    end
    repeat (20) @(negedge clk);
    check("to held timeout_err", timeout_err[0], 1);
    wmode = 0;
    fill_random();
    push_exp();
    do_start();
    check("to cleared by start", timeout_err[0], 0);
    wait_done();

    // stuck-high wr_done is only seen in the first WAIT clock
    wmode = 2;
    fill_random();
    push_exp();
    do_start();
    k = 0;
    while (!rd_en[0] && k < 20) begin @(negedge clk); k++; end
    check("stale wr_done scan delay", k, ARMC + 1);
    wait_done();
    wmode = 0;

    // start pulses during ARM, WAIT and SCAN are ignored
    fill_random();
    push_exp();
    do_start();
    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (17) @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (130) @(negedge clk);
    check("scan in progress", rd_en[0], 1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done();
    repeat (300) @(negedge clk);
    check("no restart lane0 busy", busy[0], 0);
    check("no restart lane1 busy", busy[1], 0);

    // asynchronous reset in the middle of the scan
    fill_random();
    push_exp();
    do_start();
    k = 0;
    while (!(rd_en[0] && rd_addr[0] == 8'd80) && k < 500) begin @(negedge clk); k++; end
    check("reached addr 80", {31'd0, rd_en[0] && rd_addr[0] == 8'd80}, 1);
    #1 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("mid rst lane%0d rd_en", g), rd_en[g], 0);
      check($sformatf("mid rst lane%0d busy", g), busy[g], 0);
      check($sformatf("mid rst lane%0d rd_addr", g), rd_addr[g], 0);
      check($sformatf("mid rst lane%0d peak_val", g), peak_val[g], 0);
      check($sformatf("mid rst lane%0d peak_idx", g), peak_idx[g], 0);
      check($sformatf("mid rst lane%0d above_cnt", g), above_cnt[g], 0);
    end
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    fill_random();
    run_scan();
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
